jpeg_enc_dct_sched: RTL
=======================

Name: jpeg_enc_dct_sched

Overview:
Scheduler for the 2-D DCT engine (s_conv/e_conv handshake, one du_ram, one shared dctdu_ram). It tracks a ping-pong pair of 8x8 data-unit (DU) input banks filled by the upstream block loader. It starts one DCT per filled bank, then starts the quantizer to drain dctdu_ram, and does not start the next DCT until the quantizer has finished. It also counts DUs, flags the end of a frame, and raises sticky error flags for overflow and timeout.

Parameters:
TIMEOUT, 1023, max cycles to wait for dct_e_conv or q_done before raising tmo_err (1..65535)
CNT_W, 16, width of du_count

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  pulse: upstream finished writing bank in_bank
in_comp  in  2  component id of that DU (0=Y,1=Cb,2=Cr)
in_last  in  1  DU is last of frame, qualified by in_valid
in_bank  out  1  bank upstream must write next
in_full  out  1  both banks pending; upstream must not pulse in_valid
dct_bank  out  1  bank selected onto DCT du_ram read mux
dct_s_conv  out  1  one-cycle DCT start pulse
dct_e_conv  in  1  DCT completion pulse
q_start  out  1  one-cycle quantizer start pulse
q_comp  out  2  component of DU being quantized (selects quant table)
q_done  in  1  quantizer finished reading dctdu_ram
frame_done  out  1  one-cycle pulse after the last DU of a frame is quantized
du_count  out  CNT_W  DUs quantized since reset/frame start
ovf_err  out  1  sticky: in_valid received while in_full
tmo_err  out  1  sticky: handshake timeout
clr_err  in  1  synchronous clear of ovf_err/tmo_err

Behaviour:
- Reset (async, reset_n low): state=IDLE; all outputs 0; in_bank=0, rd_bank=0, pending=0, du_count=0, timer=0. Reset mid-operation aborts instantly; a DCT or quantizer pulse that arrives afterwards is ignored.
- Bank tracking:
  - pending is 0..2.
  - accept = in_valid & !in_full. On accept, store in_comp/in_last into sideband[in_bank] and toggle in_bank.
  - release = dct_e_conv in WAIT_DCT. On release, toggle rd_bank.
  - pending_next = pending + accept - release. Simultaneous accept and release leave pending unchanged.
  - in_full is registered and equals (pending==2).
  - in_valid while in_full: the DU is dropped, no state change, ovf_err<=1. This holds even if a release occurs in the same cycle.
- dct_bank = rd_bank, held stable from START_DCT through WAIT_DCT.
- FSM, all outputs registered and decoded from the state/next-state:
  - IDLE: pending!=0 -> START_DCT.
  - START_DCT: dct_s_conv=1 for exactly 1 cycle; latch cur_comp/cur_last from sideband[rd_bank]; timer=0 -> WAIT_DCT.
  - WAIT_DCT: on dct_e_conv, release the bank -> START_Q. Otherwise timer++; at timer==TIMEOUT set tmo_err -> IDLE, releasing the bank and discarding the DU.
  - START_Q: q_start=1 for 1 cycle; q_comp=cur_comp; timer=0 -> WAIT_Q.
  - WAIT_Q: on q_done, du_count++; then cur_last -> FRAME_END, else -> IDLE. Timeout as in WAIT_DCT: set tmo_err -> IDLE, no count.
  - FRAME_END: frame_done=1 for 1 cycle; du_count<=0 on the next cycle -> IDLE.
- Latency:
  - in_valid at cycle N into an empty scheduler -> pending=1 at N+1, START_DCT at N+1, dct_s_conv high at N+2.
  - dct_e_conv at cycle M -> q_start high at M+2.
  - Back-to-back operation: next dct_s_conv no earlier than 2 cycles after q_done.
- Stray pulses: dct_e_conv outside WAIT_DCT and q_done outside WAIT_Q are ignored.
- Wrap-around: du_count wraps at 2^CNT_W without any flag. in_bank/rd_bank wrap 1->0.
- clr_err: clears both error flags. A new error in the same cycle wins; flag stays 1.
- q_comp is held until the next START_Q. in_comp=3 is passed through unchanged.

Test Plan:
- Single DU: in_valid, in_comp=0, in_last=0; e_conv 100 cycles after s_conv; q_done 70 cycles after q_start -> one s_conv with dct_bank=0, one q_start with q_comp=0, du_count=1, in_bank=1, frame_done never.
- Ping-pong fill: two in_valid 3 cycles apart while the DCT is busy -> in_full=1 after the 2nd; 3rd in_valid sets ovf_err=1 and pending stays 2; 2nd DCT uses dct_bank=1; clr_err -> ovf_err=0.
- Frame of 6 DUs with comps 0,0,0,0,1,2 and last on the 6th -> q_comp sequence 0,0,0,0,1,2; frame_done pulses 1 cycle after the 6th q_done; du_count reads 6 then 0.
- Timeout, TIMEOUT=15: withhold dct_e_conv -> tmo_err=1 exactly 15 cycles after WAIT_DCT entry; bank released (pending decrements); no q_start; next pending DU is started.
- Simultaneous events: in_valid in the same cycle as dct_e_conv with pending=1 -> pending stays 1, no ovf_err; stray q_done in IDLE -> no count change.
- Async reset asserted during WAIT_Q -> all outputs 0 immediately; a later q_done is ignored; du_count=0.

Source files
------------

// File: rtl/jpeg_enc_dct_sched.sv
// jpeg_enc_dct_sched
// Schedules the shared 2-D DCT engine and the quantizer over a ping-pong
// pair of 8x8 DU input banks. One DCT is started per filled bank; the
// quantizer then drains dctdu_ram, and the next DCT waits for it. Also
// counts DUs per frame, pulses frame_done and keeps sticky error flags.
module jpeg_enc_dct_sched #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [1:0]       in_comp,
  input  logic             in_last,
  output logic             in_bank,
  output logic             in_full,
  output logic             dct_bank,
  output logic             dct_s_conv,
  input  logic             dct_e_conv,
  output logic             q_start,
  output logic [1:0]       q_comp,
  input  logic             q_done,
  output logic             frame_done,
  output logic [CNT_W-1:0] du_count,
  output logic             ovf_err,
  output logic             tmo_err,
  input  logic             clr_err
);

  // Timer value on which the wait cycle is the last one allowed; the
  // timeout then lands exactly TIMEOUT cycles after entering the wait.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_DCT,
    WAIT_DCT,
    START_Q,
    WAIT_Q,
    FRAME_END
  } state_t;

  state_t      state;
  logic [1:0]  pending;
  logic [1:0]  pending_next;
  logic        rd_bank;
  logic [1:0]  side_comp [2];
  logic        side_last [2];
  logic [1:0]  cur_comp;
  logic        cur_last;
  logic [15:0] timer;
  logic        accept;
  logic        overflow;
  logic        timer_hit;
  logic        release_bank;

  // Bank bookkeeping: accept/overflow qualification and next pending count.
  always_comb begin
    accept       = in_valid & ~in_full;
    overflow     = in_valid & in_full;
    timer_hit    = (timer == TMO_LAST);
    // A bank is freed on DCT completion or when the DCT wait times out.
    release_bank = (state == WAIT_DCT) & (dct_e_conv | timer_hit);
    pending_next = pending + {1'b0, accept} - {1'b0, release_bank};
  end

  assign dct_bank = rd_bank;

  // Ping-pong bank state, per-bank sideband and the overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending      <= '0;
      in_full      <= 1'b0;
      in_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      ovf_err      <= 1'b0;
      side_comp[0] <= '0;
      side_comp[1] <= '0;
      side_last[0] <= 1'b0;
      side_last[1] <= 1'b0;
    end else begin
      pending <= pending_next;
      in_full <= (pending_next == 2'd2);
      if (accept) begin
        side_comp[in_bank] <= in_comp;
        side_last[in_bank] <= in_last;
        in_bank            <= ~in_bank;
      end
      if (release_bank) begin
        rd_bank <= ~rd_bank;
      end
      if (overflow) begin
        ovf_err <= 1'b1;
      end else if (clr_err) begin
        ovf_err <= 1'b0;
      end
    end
  end

  // Sequencer: DCT start, quantizer start, frame end, timeouts, DU count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      dct_s_conv <= 1'b0;
      q_start    <= 1'b0;
      q_comp     <= '0;
      frame_done <= 1'b0;
      du_count   <= '0;
      tmo_err    <= 1'b0;
      timer      <= '0;
      cur_comp   <= '0;
      cur_last   <= 1'b0;
    end else begin
      dct_s_conv <= 1'b0;
      q_start    <= 1'b0;
      frame_done <= 1'b0;
      // A timeout below in the same cycle overrides this clear.
      if (clr_err) begin
        tmo_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pending_next != 2'd0) begin
            state <= START_DCT;
          end
        end
        START_DCT: begin
          dct_s_conv <= 1'b1;
          cur_comp   <= side_comp[rd_bank];
          cur_last   <= side_last[rd_bank];
          timer      <= '0;
          state      <= WAIT_DCT;
        end
        WAIT_DCT: begin
          if (dct_e_conv) begin
            state <= START_Q;
          end else if (timer_hit) begin
            tmo_err <= 1'b1;
            state   <= IDLE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        START_Q: begin
          q_start <= 1'b1;
          q_comp  <= cur_comp;
          timer   <= '0;
          state   <= WAIT_Q;
        end
        WAIT_Q: begin
          if (q_done) begin
            du_count <= du_count + CNT_W'(1);
            if (cur_last) begin
              frame_done <= 1'b1;
              state      <= FRAME_END;
            end else begin
              state <= IDLE;
            end
          end else if (timer_hit) begin
            tmo_err <= 1'b1;
            state   <= IDLE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        FRAME_END: begin
          du_count <= '0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
